// File: rtl/cnn_feed_ctrl_pkg.sv
// Shared CNN types and default sizes for the PE feed sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_feed_ctrl_pkg;

    localparam int CNN_ICP_NUM = 4;   // input-channel lanes
    localparam int CNN_XLEN    = 8;   // activation / weight word width
    localparam int CNN_ADDR_B  = 4;   // weight-buffer address width
    localparam int CNN_POS_B   = 8;   // output-position counter width
    localparam int CNN_POOL_W  = 2;   // output positions per pooling window

    // State broadcast to every PE in PE_IN_PACKET.
    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        CONV     = 2'd1,
        POOL_FIN = 2'd2
    } PE_STATE;

    // Sequencer states. The ST_ prefix keeps these apart from the PE_STATE
    // literals, which share the package namespace.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CONV = 3'd2,
        ST_POOL = 3'd3,
        ST_DONE = 3'd4
    } FEED_FSM;

endpackage

// File: rtl/cnn_feed_cnt.sv
// Lane / tap / position counters shared by weight load and activation stream.
// Latency: counters advance on the clock after a step; flags are combinational on the counts.
// Backpressure: none; steps only when the parent reports an accepted handshake.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   clr_i               zero all counters (held while the parent is idle)
//   load_step_i         advance lane, carry into tap (weight word accepted)
//   conv_step_i         advance tap, carry into pos/window (activation accepted)
//   klen_i, npos_i      last tap index, last position index
//   lane_o, tap_o       current lane and tap (tap doubles as weight address)
//   load_last_o         current weight word is the final one of the layer
//   tap_last_o          tap is at its last value
//   win_last_o          position closes a full pooling window
//   pos_last_o          position is the final one of the layer
module cnn_feed_cnt
    import cnn_feed_ctrl_pkg::*;
#(
    parameter int ICP_NUM = CNN_ICP_NUM,
    parameter int ADDR_B  = CNN_ADDR_B,
    parameter int POS_B   = CNN_POS_B,
    parameter int POOL_W  = CNN_POOL_W,
    parameter int LANE_B  = (ICP_NUM > 1) ? $clog2(ICP_NUM) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              load_step_i,
    input  logic              conv_step_i,
    input  logic [ADDR_B-1:0] klen_i,
    input  logic [POS_B-1:0]  npos_i,
    output logic [LANE_B-1:0] lane_o,
    output logic [ADDR_B-1:0] tap_o,
    output logic              load_last_o,
    output logic              tap_last_o,
    output logic              win_last_o,
    output logic              pos_last_o
);

    localparam int WIN_B = (POOL_W > 1) ? $clog2(POOL_W) : 1;

    logic [LANE_B-1:0] lane_q, lane_d;
    logic [ADDR_B-1:0] tap_q,  tap_d;
    logic [POS_B-1:0]  pos_q,  pos_d;
    logic [WIN_B-1:0]  win_q,  win_d;   // position within the current pooling window

    logic lane_last;

    assign lane_last   = (lane_q == LANE_B'(ICP_NUM - 1));
    assign tap_last_o  = (tap_q == klen_i);
    assign pos_last_o  = (pos_q == npos_i);
    assign win_last_o  = (win_q == WIN_B'(POOL_W - 1));
    assign load_last_o = lane_last && tap_last_o;
    assign lane_o      = lane_q;
    assign tap_o       = tap_q;

    always_comb begin
        lane_d = lane_q;
        tap_d  = tap_q;
        pos_d  = pos_q;
        win_d  = win_q;
        if (clr_i) begin
            lane_d = '0;
            tap_d  = '0;
            pos_d  = '0;
            win_d  = '0;
        end else if (load_step_i) begin
            // Weight word i goes to lane i mod ICP_NUM, address i div ICP_NUM.
            // The tap wraps to 0 after the last word, which is where CONV starts.
            if (lane_last) begin
                lane_d = '0;
                tap_d  = tap_last_o ? '0 : tap_q + 1'b1;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end else if (conv_step_i) begin
            if (tap_last_o) begin
                tap_d = '0;
                pos_d = pos_last_o ? '0 : pos_q + 1'b1;
                // The window restarts after a full window or the final partial one.
                win_d = (win_last_o || pos_last_o) ? '0 : win_q + 1'b1;
            end else begin
                tap_d = tap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            tap_q  <= '0;
            pos_q  <= '0;
            win_q  <= '0;
        end else begin
            lane_q <= lane_d;
            tap_q  <= tap_d;
            pos_q  <= pos_d;
            win_q  <= win_d;
        end
    end

endmodule

// File: rtl/cnn_feed_ctrl.sv
// Sequencer feeding PE_IN_PACKET: loads layer weights, then streams activations with POOL_FIN marks.
// Latency: a handshake accepted in cycle t shows on the registered packet outputs in cycle t+1.
// Backpressure: w_ready only in LOAD, a_ready only in CONV; stall cycles emit wrb=0 / pe_state=INVALID.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, cfg_klen, cfg_npos  layer start with taps-1 and positions-1 (sampled in IDLE)
//   w_valid/w_data/w_ready     weight word stream
//   a_valid/a_data/a_ready     activation vector stream, lane j at [j*DATA_WID +: DATA_WID]
//   pe_state, A, wrb_data,     packet fields to the PEs
//   wrb, wrb_addr, rdb_addr
//   busy, done                 layer in progress / one-cycle end-of-layer pulse
module cnn_feed_ctrl
    import cnn_feed_ctrl_pkg::*;
#(
    parameter int ICP_NUM  = CNN_ICP_NUM,
    parameter int DATA_WID = CNN_XLEN,
    parameter int ADDR_B   = CNN_ADDR_B,
    parameter int POS_B    = CNN_POS_B,
    parameter int POOL_W   = CNN_POOL_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_B-1:0]            cfg_klen,
    input  logic [POS_B-1:0]             cfg_npos,
    input  logic                         w_valid,
    input  logic [DATA_WID-1:0]          w_data,
    output logic                         w_ready,
    input  logic                         a_valid,
    input  logic [ICP_NUM*DATA_WID-1:0]  a_data,
    output logic                         a_ready,
    output PE_STATE                      pe_state,
    output logic [ICP_NUM*DATA_WID-1:0]  A,
    output logic [DATA_WID-1:0]          wrb_data,
    output logic [ICP_NUM-1:0]           wrb,
    output logic [ADDR_B-1:0]            wrb_addr,
    output logic [ADDR_B-1:0]            rdb_addr,
    output logic                         busy,
    output logic                         done
);

    localparam int LANE_B = (ICP_NUM > 1) ? $clog2(ICP_NUM) : 1;

    FEED_FSM st_q, st_d;

    logic [ADDR_B-1:0]           klen_q;
    logic [POS_B-1:0]            npos_q;
    logic                        cfg_ld;
    logic                        last_win_q, last_win_d;  // POOL window being closed is the layer's last

    PE_STATE                     pe_state_q, pe_state_d;
    logic [ICP_NUM*DATA_WID-1:0] a_q,        a_d;
    logic [DATA_WID-1:0]         wrb_data_q, wrb_data_d;
    logic [ICP_NUM-1:0]          wrb_q,      wrb_d;
    logic [ADDR_B-1:0]           wrb_addr_q, wrb_addr_d;
    logic [ADDR_B-1:0]           rdb_addr_q, rdb_addr_d;
    logic                        busy_q,     busy_d;
    logic                        done_q,     done_d;

    logic              w_hs, a_hs;
    logic [LANE_B-1:0] cnt_lane;
    logic [ADDR_B-1:0] cnt_tap;
    logic              cnt_load_last, cnt_tap_last, cnt_win_last, cnt_pos_last;

    assign w_ready = (st_q == ST_LOAD);
    assign a_ready = (st_q == ST_CONV);
    assign w_hs    = w_valid && w_ready;
    assign a_hs    = a_valid && a_ready;

    cnn_feed_cnt #(
        .ICP_NUM (ICP_NUM),
        .ADDR_B  (ADDR_B),
        .POS_B   (POS_B),
        .POOL_W  (POOL_W),
        .LANE_B  (LANE_B)
    ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (st_q == ST_IDLE),
        .load_step_i (w_hs),
        .conv_step_i (a_hs),
        .klen_i      (klen_q),
        .npos_i      (npos_q),
        .lane_o      (cnt_lane),
        .tap_o       (cnt_tap),
        .load_last_o (cnt_load_last),
        .tap_last_o  (cnt_tap_last),
        .win_last_o  (cnt_win_last),
        .pos_last_o  (cnt_pos_last)
    );

    always_comb begin
        st_d       = st_q;
        cfg_ld     = 1'b0;
        last_win_d = last_win_q;
        pe_state_d = INVALID;
        a_d        = a_q;
        wrb_data_d = wrb_data_q;
        wrb_d      = '0;
        wrb_addr_d = wrb_addr_q;
        rdb_addr_d = rdb_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_ld = 1'b1;
                    busy_d = 1'b1;
                    st_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_hs) begin
                    wrb_d[cnt_lane] = 1'b1;
                    wrb_addr_d      = cnt_tap;
                    wrb_data_d      = w_data;
                    if (cnt_load_last) begin
                        st_d = ST_CONV;
                    end
                end
            end
            ST_CONV: begin
                if (a_hs) begin
                    pe_state_d = CONV;
                    a_d        = a_data;
                    rdb_addr_d = cnt_tap;
                    if (cnt_tap_last && (cnt_win_last || cnt_pos_last)) begin
                        last_win_d = cnt_pos_last;
                        st_d       = ST_POOL;
                    end
                end
            end
            ST_POOL: begin
                pe_state_d = POOL_FIN;
                st_d       = last_win_q ? ST_DONE : ST_CONV;
            end
            ST_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                st_d   = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= ST_IDLE;
            klen_q     <= '0;
            npos_q     <= '0;
            last_win_q <= 1'b0;
            pe_state_q <= INVALID;
            a_q        <= '0;
            wrb_data_q <= '0;
            wrb_q      <= '0;
            wrb_addr_q <= '0;
            rdb_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            last_win_q <= last_win_d;
            if (cfg_ld) begin
                klen_q <= cfg_klen;
                npos_q <= cfg_npos;
            end
            pe_state_q <= pe_state_d;
            a_q        <= a_d;
            wrb_data_q <= wrb_data_d;
            wrb_q      <= wrb_d;
            wrb_addr_q <= wrb_addr_d;
            rdb_addr_q <= rdb_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pe_state = pe_state_q;
    assign A        = a_q;
    assign wrb_data = wrb_data_q;
    assign wrb      = wrb_q;
    assign wrb_addr = wrb_addr_q;
    assign rdb_addr = rdb_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_cnn_feed_ctrl.sv
// Bench for cnn_feed_ctrl: random weight/activation streams against a phase-level reference model.
// Latency: model expects every accepted handshake on the packet outputs one cycle later.
// Backpressure: valid patterns are always-on, alternating or random per layer.
module tb_cnn_feed_ctrl;
    import cnn_feed_ctrl_pkg::*;

    localparam int ICP = 4;
    localparam int DW  = 8;
    localparam int AB  = 4;
    localparam int PB  = 8;
    localparam int PW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AB-1:0]     cfg_klen;
    logic [PB-1:0]     cfg_npos;
    logic              w_valid;
    logic [DW-1:0]     w_data;
    logic              w_ready;
    logic              a_valid;
    logic [ICP*DW-1:0] a_data;
    logic              a_ready;
    PE_STATE           pe_state;
    logic [ICP*DW-1:0] A;
    logic [DW-1:0]     wrb_data;
    logic [ICP-1:0]    wrb;
    logic [AB-1:0]     wrb_addr;
    logic [AB-1:0]     rdb_addr;
    logic              busy;
    logic              done;

    cnn_feed_ctrl #(
        .ICP_NUM (ICP), .DATA_WID (DW), .ADDR_B (AB), .POS_B (PB), .POOL_W (PW)
    ) dut (
        .clk      (clk),      .reset    (reset),    .start    (start),
        .cfg_klen (cfg_klen), .cfg_npos (cfg_npos),
        .w_valid  (w_valid),  .w_data   (w_data),   .w_ready  (w_ready),
        .a_valid  (a_valid),  .a_data   (a_data),   .a_ready  (a_ready),
        .pe_state (pe_state), .A        (A),        .wrb_data (wrb_data),
        .wrb      (wrb),      .wrb_addr (wrb_addr), .rdb_addr (rdb_addr),
        .busy     (busy),     .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_LOAD, M_CONV, M_POOL, M_DONE} ph_t;
    ph_t ph = M_IDLE;
    int  mk = 0, mn = 0, wcnt = 0, vcnt = 0, pos = 0;
    bit  mlast = 1'b0;
    bit  armed = 1'b0;

    logic [ICP-1:0]    e_wrb   = '0;
    logic [AB-1:0]     e_waddr = '0;
    logic [AB-1:0]     e_raddr = '0;
    logic [DW-1:0]     e_wdata = '0;
    logic [ICP*DW-1:0] e_a     = '0;
    int                e_pe    = 0;
    bit                e_done  = 1'b0;

    // Inputs as seen just before the previous active edge.
    bit                p_rst = 1'b0, p_start = 1'b0, p_whs = 1'b0, p_ahs = 1'b0;
    logic [DW-1:0]     p_wd = '0;
    logic [ICP*DW-1:0] p_ad = '0;
    int                p_k = 0, p_n = 0;

    int pool_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (p_rst) begin
            ph      = M_IDLE;
            e_wrb   = '0; e_waddr = '0; e_raddr = '0; e_wdata = '0; e_a = '0;
            e_pe    = int'(INVALID);
            e_done  = 1'b0;
            armed   = 1'b1;
        end else begin
            e_wrb  = '0;
            e_pe   = int'(INVALID);
            e_done = 1'b0;
            case (ph)
                M_IDLE: if (p_start) begin
                    mk = p_k; mn = p_n; wcnt = 0; vcnt = 0; ph = M_LOAD;
                end
                M_LOAD: if (p_whs) begin
                    e_wrb[wcnt % ICP] = 1'b1;
                    e_waddr = AB'(wcnt / ICP);
                    e_wdata = p_wd;
                    wcnt++;
                    if (wcnt == ICP * (mk + 1)) ph = M_CONV;
                end
                M_CONV: if (p_ahs) begin
                    e_pe    = int'(CONV);
                    e_a     = p_ad;
                    e_raddr = AB'(vcnt % (mk + 1));
                    vcnt++;
                    if (vcnt % (mk + 1) == 0) begin
                        pos = vcnt / (mk + 1) - 1;
                        if (((pos + 1) % PW == 0) || (pos == mn)) begin
                            mlast = (pos == mn);
                            ph    = M_POOL;
                        end
                    end
                end
                M_POOL: begin
                    e_pe = int'(POOL_FIN);
                    ph   = mlast ? M_DONE : M_CONV;
                end
                M_DONE: begin
                    e_done = 1'b1;
                    ph     = M_IDLE;
                end
                default: ph = M_IDLE;
            endcase
        end

        if (armed) begin
            chk("wrb",      wrb,      e_wrb);
            chk("wrb_addr", wrb_addr, e_waddr);
            chk("wrb_data", wrb_data, e_wdata);
            chk("pe_state", pe_state, e_pe);
            chk("A",        A,        e_a);
            chk("rdb_addr", rdb_addr, e_raddr);
            chk("done",     done,     e_done);
            chk("busy",     busy,     ph != M_IDLE);
            chk("w_ready",  w_ready,  ph == M_LOAD);
            chk("a_ready",  a_ready,  ph == M_CONV);
            if (pe_state == POOL_FIN) pool_cnt++;
            if (done) done_cnt++;
        end

        p_rst   = reset;
        p_start = start;
        p_whs   = w_valid && w_ready;
        p_ahs   = a_valid && a_ready;
        p_wd    = w_data;
        p_ad    = a_data;
        p_k     = int'(cfg_klen);
        p_n     = int'(cfg_npos);
    end

    // ---------------- stimulus ----------------
    function automatic logic vld(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2 == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // mode: 0 always valid, 1 alternating, 2 random.
    // rst_vec: nonzero pulses reset after that many vectors and abandons the layer.
    // noise: pulses start and a_valid while busy / loading, which must be ignored.
    task automatic run_layer(input int k, input int n, input int mode, input int rst_vec, input bit noise);
        int nw, nv, wi, vi, cyc, p0, d0;
        bit hs;
        nw = ICP * (k + 1);
        nv = (k + 1) * (n + 1);
        wi = 0; vi = 0; cyc = 0;
        p0 = pool_cnt; d0 = done_cnt;
        cfg_klen = AB'(k);
        cfg_npos = PB'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (wi < nw && cyc < 2000) begin
            w_valid = vld(mode, cyc);
            w_data  = DW'($urandom);
            a_valid = noise;
            a_data  = (ICP*DW)'($urandom);
            start   = noise && (cyc == 1);
            if (noise) cfg_klen = AB'($urandom);
            @(negedge clk);
            if (w_valid && w_ready) wi++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("weights_taken", wi, nw);
        w_valid = 1'b0;
        start   = 1'b0;
        while (vi < nv && cyc < 4000) begin
            a_valid = vld(mode, cyc);
            a_data  = (ICP*DW)'($urandom);
            start   = noise && (vi == 1);
            @(negedge clk);
            hs = a_valid && a_ready;
            if (hs) vi++;
            @(posedge clk); #1;
            cyc++;
            if (hs && rst_vec != 0 && vi == rst_vec) begin
                a_valid = 1'b0;
                start   = 1'b0;
                reset   = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("rst_pe",   pe_state, INVALID);
                chk("rst_busy", busy, 1'b0);
                chk("rst_A",    A, '0);
                chk("rst_rdy",  {w_ready, a_ready}, 2'b00);
                @(posedge clk); #1;
                return;
            end
        end
        chk("vectors_taken", vi, nv);
        a_valid = 1'b0;
        start   = 1'b0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        chk("done_count", done_cnt - d0, 1);
        chk("pool_count", pool_cnt - p0, (n + PW) / PW);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        cfg_klen = '0;
        cfg_npos = '0;
        w_valid  = 1'b0;
        w_data   = '0;
        a_valid  = 1'b0;
        a_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_wrb",  wrb, '0);
        @(posedge clk); #1;

        run_layer(1, 1, 0, 0, 1'b0);   // load 8 words, one full window
        run_layer(0, 2, 0, 0, 1'b0);   // 3 positions, partial last window
        run_layer(1, 1, 1, 0, 1'b0);   // alternating valid
        run_layer(1, 3, 0, 2, 1'b0);   // reset after 2nd vector
        run_layer(1, 1, 0, 0, 1'b0);   // clean reload after reset
        run_layer(1, 1, 0, 0, 1'b1);   // start and a_valid noise while busy
        run_layer(0, 0, 0, 0, 1'b0);   // single tap, single position
        for (int i = 0; i < 6; i++) begin
            run_layer($urandom_range(0, 3), $urandom_range(0, 5), 2, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
